// File: rtl/multiplier_seq.sv
// Sequential shift-and-add multiplier with a Wishbone-style strobe/ack handshake.
// Operands are reduced to magnitudes, multiplied BITS_PER_CYCLE bits per cycle,
// and the product is negated at the end when exactly one operand was negative.
// The last full product can be kept and returned immediately when the same
// operands are requested again, for example a high-half request followed by a
// low-half request.
module multiplier_seq #(
    parameter int XLEN            = 32,  // 32 or 64
    parameter int BITS_PER_CYCLE  = 1,   // 1, 2 or 4; must divide XLEN
    parameter int EARLY_TERMINATE = 1,
    parameter int RESULT_CACHE    = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stb_i,
    input  logic            cyc_i,
    input  logic [XLEN-1:0] op_1_i,
    input  logic            op_1_is_signed_i,
    input  logic [XLEN-1:0] op_2_i,
    input  logic            op_2_is_signed_i,
    input  logic            result_upper_i,
    output logic [XLEN-1:0] result_o,
    output logic            ack_o,
    output logic            busy_o
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [2*XLEN-1:0] ONE_WIDE = {{(2*XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
        NEGATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [CW-1:0]     count;
    logic              sign;
    logic              ack_q;

    logic [2*XLEN-1:0] cache_product;
    logic [XLEN-1:0]   cache_op_1;
    logic [XLEN-1:0]   cache_op_2;
    logic              cache_op_1_signed;
    logic              cache_op_2_signed;
    logic              cache_valid;

    logic              op_1_neg;
    logic              op_2_neg;
    logic [XLEN-1:0]   op_1_mag;
    logic [XLEN-1:0]   op_2_mag;
    logic              sign_next;
    logic              request;
    logic              cache_hit;
    logic [XLEN-1:0]   mplier_next;
    logic              last_step;
    logic [2*XLEN-1:0] partial;

    // Operand magnitudes, request/cache decode and loop-exit condition.
    always_comb begin
        op_1_neg  = op_1_is_signed_i & op_1_i[XLEN-1];
        op_2_neg  = op_2_is_signed_i & op_2_i[XLEN-1];
        // The most-negative value maps onto itself, which read unsigned is
        // exactly its magnitude, so no extra bit is needed.
        op_1_mag  = op_1_neg ? (~op_1_i + XLEN'(1)) : op_1_i;
        op_2_mag  = op_2_neg ? (~op_2_i + XLEN'(1)) : op_2_i;
        // A zero multiplier with early exit skips the NEGATE pass entirely.
        sign_next = (op_1_neg ^ op_2_neg) &
                    ~((EARLY_TERMINATE != 0) && (op_2_mag == '0));
        request   = stb_i & cyc_i & ~ack_q;
        cache_hit = (RESULT_CACHE != 0) && cache_valid &&
                    (op_1_i == cache_op_1) && (op_2_i == cache_op_2) &&
                    (op_1_is_signed_i == cache_op_1_signed) &&
                    (op_2_is_signed_i == cache_op_2_signed);
        mplier_next = mplier >> BITS_PER_CYCLE;
        last_step   = (count == CW'(STEPS - 1)) ||
                      ((EARLY_TERMINATE != 0) && (mplier_next == '0));
    end

    // Partial product for the low BITS_PER_CYCLE multiplier bits.
    always_comb begin
        // NOTE: assigning a default before the loop keeps every path driven,
        // so no latch is inferred for the conditional accumulation below.
        partial = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mplier[k]) begin
                partial = partial + (mcand << k);
            end
        end
    end

    // Control FSM together with the datapath and cache registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the datapath and cache registers are reset as well; result_o
            // must read zero after reset and the cache tags must not match
            // stale X values in simulation.
            state             <= IDLE;
            acc               <= '0;
            mcand             <= '0;
            mplier            <= '0;
            count             <= '0;
            sign              <= 1'b0;
            ack_q             <= 1'b0;
            result_o          <= '0;
            cache_product     <= '0;
            cache_op_1        <= '0;
            cache_op_2        <= '0;
            cache_op_1_signed <= 1'b0;
            cache_op_2_signed <= 1'b0;
            cache_valid       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge value of the others, independent of statement order.
            case (state)
                IDLE: begin
                    // ack stays up while the master keeps stb_i high, then clears.
                    if (ack_q) begin
                        ack_q <= stb_i;
                    end
                    if (request) begin
                        if (cache_hit) begin
                            acc   <= cache_product;
                            state <= DONE;
                        end else begin
                            mcand  <= {{XLEN{1'b0}}, op_1_mag};
                            mplier <= op_2_mag;
                            sign   <= sign_next;
                            acc    <= '0;
                            count  <= '0;
                            state  <= MUL;
                            if (RESULT_CACHE != 0) begin
                                // Tags are captured now; the entry becomes valid in DONE.
                                cache_valid       <= 1'b0;
                                cache_op_1        <= op_1_i;
                                cache_op_2        <= op_2_i;
                                cache_op_1_signed <= op_1_is_signed_i;
                                cache_op_2_signed <= op_2_is_signed_i;
                            end
                        end
                    end
                end
                MUL: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier_next;
                    count  <= count + CW'(1);
                    if (last_step) begin
                        state <= sign ? NEGATE : DONE;
                    end
                end
                NEGATE: begin
                    acc   <= ~acc + ONE_WIDE;
                    state <= DONE;
                end
                DONE: begin
                    result_o <= result_upper_i ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
                    ack_q    <= 1'b1;
                    if (RESULT_CACHE != 0) begin
                        cache_product <= acc;
                        cache_valid   <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ack_o  = ack_q & stb_i;
    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_multiplier_seq.sv
// Directed bench for multiplier_seq. Three instances share clock and reset:
//   dut_a: XLEN=32, BITS_PER_CYCLE=2, no early exit   (shares inputs with dut_b)
//   dut_b: XLEN=32, BITS_PER_CYCLE=1, early exit
//   dut_c: XLEN=64, BITS_PER_CYCLE=4, early exit
// Expected products and ack latencies are pushed to per-instance queues when a
// request is driven and popped when that instance raises ack_o.
module tb_multiplier_seq;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        stb32, cyc32, s1_32, s2_32, up32;
    logic [31:0] op1_32, op2_32;
    logic [31:0] res_a, res_b;
    logic        ack_a, ack_b, busy_a, busy_b;

    logic        stb64, cyc64, s1_64, s2_64, up64;
    logic [63:0] op1_64, op2_64;
    logic [63:0] res_c;
    logic        ack_c, busy_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    // Bench-side cache model: the last completed operand set per width.
    logic        m32_valid, m64_valid;
    logic [31:0] m32_a, m32_b;
    logic        m32_sa, m32_sb;
    logic [63:0] m64_a, m64_b;
    logic        m64_sa, m64_sb;

    int total;
    int bad;

    multiplier_seq #(.XLEN(32), .BITS_PER_CYCLE(2), .EARLY_TERMINATE(0), .RESULT_CACHE(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .stb_i(stb32), .cyc_i(cyc32),
        .op_1_i(op1_32), .op_1_is_signed_i(s1_32),
        .op_2_i(op2_32), .op_2_is_signed_i(s2_32),
        .result_upper_i(up32), .result_o(res_a), .ack_o(ack_a), .busy_o(busy_a)
    );

    multiplier_seq #(.XLEN(32), .BITS_PER_CYCLE(1), .EARLY_TERMINATE(1), .RESULT_CACHE(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .stb_i(stb32), .cyc_i(cyc32),
        .op_1_i(op1_32), .op_1_is_signed_i(s1_32),
        .op_2_i(op2_32), .op_2_is_signed_i(s2_32),
        .result_upper_i(up32), .result_o(res_b), .ack_o(ack_b), .busy_o(busy_b)
    );

    multiplier_seq #(.XLEN(64), .BITS_PER_CYCLE(4), .EARLY_TERMINATE(1), .RESULT_CACHE(1)) dut_c (
        .clk_i(clk), .rst_i(rst), .stb_i(stb64), .cyc_i(cyc64),
        .op_1_i(op1_64), .op_1_is_signed_i(s1_64),
        .op_2_i(op2_64), .op_2_is_signed_i(s2_64),
        .result_upper_i(up64), .result_o(res_c), .ack_o(ack_c), .busy_o(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full 2*xlen-bit product, computed by sign/zero-extending to 128 bits.
    function automatic logic [127:0] model_prod(input logic [63:0] a, input bit sa,
                                                input logic [63:0] b, input bit sb,
                                                input int xlen);
        logic [127:0] ea, eb;
        for (int i = 0; i < 128; i++) begin
            if (i < xlen) begin
                ea[i] = a[i];
                eb[i] = b[i];
            end else begin
                ea[i] = sa & a[xlen-1];
                eb[i] = sb & b[xlen-1];
            end
        end
        return ea * eb;
    endfunction

    function automatic logic [63:0] magnitude(input logic [63:0] v, input bit s, input int xlen);
        logic [63:0] mask;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        if (s && v[xlen-1]) return (~v + 64'd1) & mask;
        return v & mask;
    endfunction

    // Multiply cycles with early exit: shift until the multiplier is empty, at least one.
    function automatic int early_cycles(input logic [63:0] mag, input int bpc);
        int n;
        logic [63:0] m;
        n = 0;
        m = mag;
        do begin
            m = m >> bpc;
            n++;
        end while (m != 64'd0);
        return n;
    endfunction

    task automatic run32(input string tag, input logic [31:0] a, input bit sa,
                         input logic [31:0] b, input bit sb, input bit up);
        logic [127:0] p;
        logic [63:0]  ev, mag2;
        exp_t         ea, eb, got;
        bit           hit, neg, got_a, got_b;
        int           edges;
        p    = model_prod({32'd0, a}, sa, {32'd0, b}, sb, 32);
        ev   = up ? {32'd0, p[63:32]} : {32'd0, p[31:0]};
        hit  = m32_valid && (m32_a == a) && (m32_b == b) && (m32_sa == sa) && (m32_sb == sb);
        mag2 = magnitude({32'd0, b}, sb, 32);
        neg  = (sa & a[31]) ^ (sb & b[31]);
        ea.res = ev;
        ea.lat = hit ? 2 : 16 + 2 + (neg ? 1 : 0);
        eb.res = ev;
        eb.lat = hit ? 2 : early_cycles(mag2, 1) + 2 + ((neg && mag2 != 64'd0) ? 1 : 0);
        q_a.push_back(ea);
        q_b.push_back(eb);

        @(negedge clk);
        op1_32 = a; s1_32 = sa; op2_32 = b; s2_32 = sb; up32 = up;
        stb32 = 1'b1; cyc32 = 1'b1;
        got_a = 1'b0; got_b = 1'b0; edges = 0;
        // Edge 1 is the accept edge.
        while (!(got_a && got_b) && edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
            if (ack_a && !got_a) begin
                got_a = 1'b1;
                got = q_a.pop_front();
                check({tag, "_a_res"}, {32'd0, res_a}, got.res);
                check({tag, "_a_lat"}, 64'(edges), 64'(got.lat));
            end
            if (ack_b && !got_b) begin
                got_b = 1'b1;
                got = q_b.pop_front();
                check({tag, "_b_res"}, {32'd0, res_b}, got.res);
                check({tag, "_b_lat"}, 64'(edges), 64'(got.lat));
            end
        end
        check({tag, "_a_acked"}, 64'(got_a), 64'd1);
        check({tag, "_b_acked"}, 64'(got_b), 64'd1);
        if (!got_a && q_a.size() != 0) void'(q_a.pop_front());
        if (!got_b && q_b.size() != 0) void'(q_b.pop_front());

        @(negedge clk);
        stb32 = 1'b0; cyc32 = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_ack_clear"}, {62'd0, ack_a, ack_b}, 64'd0);
        m32_valid = 1'b1; m32_a = a; m32_b = b; m32_sa = sa; m32_sb = sb;
    endtask

    task automatic run64(input string tag, input logic [63:0] a, input bit sa,
                         input logic [63:0] b, input bit sb, input bit up);
        logic [127:0] p;
        logic [63:0]  mag2;
        exp_t         ec, got;
        bit           hit, neg, got_c;
        int           edges;
        p    = model_prod(a, sa, b, sb, 64);
        hit  = m64_valid && (m64_a == a) && (m64_b == b) && (m64_sa == sa) && (m64_sb == sb);
        mag2 = magnitude(b, sb, 64);
        neg  = (sa & a[63]) ^ (sb & b[63]);
        ec.res = up ? p[127:64] : p[63:0];
        ec.lat = hit ? 2 : early_cycles(mag2, 4) + 2 + ((neg && mag2 != 64'd0) ? 1 : 0);
        q_c.push_back(ec);

        @(negedge clk);
        op1_64 = a; s1_64 = sa; op2_64 = b; s2_64 = sb; up64 = up;
        stb64 = 1'b1; cyc64 = 1'b1;
        got_c = 1'b0; edges = 0;
        while (!got_c && edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
            if (ack_c) begin
                got_c = 1'b1;
                got = q_c.pop_front();
                check({tag, "_c_res"}, res_c, got.res);
                check({tag, "_c_lat"}, 64'(edges), 64'(got.lat));
            end
        end
        check({tag, "_c_acked"}, 64'(got_c), 64'd1);
        if (!got_c && q_c.size() != 0) void'(q_c.pop_front());

        @(negedge clk);
        stb64 = 1'b0; cyc64 = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_c_ack_clear"}, 64'(ack_c), 64'd0);
        m64_valid = 1'b1; m64_a = a; m64_b = b; m64_sa = sa; m64_sb = sb;
    endtask

    initial begin
        bit          seen;
        logic [31:0] ra, rb;
        bit          rsa, rsb, rup;

        total = 0; bad = 0;
        m32_valid = 1'b0; m64_valid = 1'b0;
        m32_a = '0; m32_b = '0; m32_sa = 1'b0; m32_sb = 1'b0;
        m64_a = '0; m64_b = '0; m64_sa = 1'b0; m64_sb = 1'b0;
        rst = 1'b1;
        stb32 = 1'b0; cyc32 = 1'b0; op1_32 = '0; op2_32 = '0; s1_32 = 1'b0; s2_32 = 1'b0; up32 = 1'b0;
        stb64 = 1'b0; cyc64 = 1'b0; op1_64 = '0; op2_64 = '0; s1_64 = 1'b0; s2_64 = 1'b0; up64 = 1'b0;

        // Reset state.
        #1;
        check("rst_res_a", {32'd0, res_a}, 64'd0);
        check("rst_outs", {58'd0, ack_a, busy_a, ack_b, busy_b, ack_c, busy_c}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic unsigned product; dut_a gives the full-length latency.
        run32("mul_7x6", 32'd7, 1'b0, 32'd6, 1'b0, 1'b0);
        // Early exit with a one-bit multiplier.
        run32("mul_op2_1", 32'h1234_5678, 1'b0, 32'd1, 1'b0, 1'b0);
        // High-half variants on all-ones operands.
        run32("mulh_ff", 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        run32("mulhu_ff", 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run32("mulhsu_ff", 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        // Most-negative operands and a zero multiplier with a negative multiplicand.
        run32("mulh_minmin", 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
        run32("mul_neg_x0", 32'h8000_0000, 1'b1, 32'd0, 1'b1, 1'b1);
        // High half then low half of the same operands: the second is a cache hit.
        run32("cache_mulh", 32'h1234_5678, 1'b1, 32'h9ABC_DEF0, 1'b1, 1'b1);
        run32("cache_mul", 32'h1234_5678, 1'b1, 32'h9ABC_DEF0, 1'b1, 1'b0);
        check("cache_mul_const", {32'd0, res_a}, 64'h0000_0000_242D_2080);

        // Strobe withdrawn mid-operation: no ack, operation still completes.
        @(negedge clk);
        op1_32 = 32'd5; s1_32 = 1'b0; op2_32 = 32'd7; s2_32 = 1'b0; up32 = 1'b0;
        stb32 = 1'b1; cyc32 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        stb32 = 1'b0; cyc32 = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            seen = seen | ack_a | ack_b;
        end
        check("drop_no_ack", 64'(seen), 64'd0);
        check("drop_idle", {62'd0, busy_a, busy_b}, 64'd0);
        m32_valid = 1'b1; m32_a = 32'd5; m32_b = 32'd7; m32_sa = 1'b0; m32_sb = 1'b0;
        run32("drop_rehit", 32'd5, 1'b0, 32'd7, 1'b0, 1'b0);

        // Reset pulse in the middle of a long multiply.
        @(negedge clk);
        op1_32 = 32'd3; s1_32 = 1'b0; op2_32 = 32'hFFFF_FFFF; s2_32 = 1'b0; up32 = 1'b0;
        stb32 = 1'b1; cyc32 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("busy_before_rst", {62'd0, busy_a, busy_b}, 64'd3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_outs", {60'd0, ack_a, busy_a, ack_b, busy_b}, 64'd0);
        check("rst_mid_res", {res_a, res_b}, 64'd0);
        stb32 = 1'b0; cyc32 = 1'b0;
        m32_valid = 1'b0; m64_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen = seen | ack_a | ack_b;
        end
        check("rst_mid_no_ack", 64'(seen), 64'd0);

        // First request after reset; the earlier cached operands must miss.
        run32("post_rst", 32'd5, 1'b0, 32'd7, 1'b0, 1'b0);

        // A few random operand sets.
        for (int i = 0; i < 4; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rsa = 1'($urandom_range(0, 1));
            rsb = 1'($urandom_range(0, 1));
            rup = 1'($urandom_range(0, 1));
            run32($sformatf("rand%0d", i), ra, rsa, rb, rsb, rup);
        end

        // 64-bit instance: most-negative times two, both halves; then unsigned all-ones.
        run64("w64_hi", 64'h8000_0000_0000_0000, 1'b1, 64'd2, 1'b1, 1'b1);
        check("w64_hi_const", res_c, 64'hFFFF_FFFF_FFFF_FFFF);
        run64("w64_lo", 64'h8000_0000_0000_0000, 1'b1, 64'd2, 1'b1, 1'b0);
        check("w64_lo_const", res_c, 64'd0);
        run64("w64_ffu", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiplier_seq.md
MULTIPLIER_SEQ -- requirements
Module: multiplier_seq

Interface
REQ-001 Parameter XLEN, default 32, operand width; legal values 32 and 64.
REQ-002 Parameter BITS_PER_CYCLE, default 1, multiplier bits consumed per MUL cycle; legal values 1, 2, 4; must divide XLEN.
REQ-003 Parameter EARLY_TERMINATE, default 1, when 1 iteration stops once remaining multiplier bits are all zero.
REQ-004 Parameter RESULT_CACHE, default 1, when 1 the last full product is retained for reuse.
REQ-005 Port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 Port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 Port stb_i  input  1  request strobe; held high until ack_o is seen.
REQ-008 Port cyc_i  input  1  bus cycle valid; a request requires stb_i & cyc_i.
REQ-009 Port op_1_i  input  XLEN  multiplicand; held stable while stb_i high.
REQ-010 Port op_1_is_signed_i  input  1  op_1_i is two's complement.
REQ-011 Port op_2_i  input  XLEN  multiplier; held stable while stb_i high.
REQ-012 Port op_2_is_signed_i  input  1  op_2_i is two's complement.
REQ-013 Port result_upper_i  input  1  1 selects product[2*XLEN-1:XLEN], 0 selects product[XLEN-1:0].
REQ-014 Port result_o  output  XLEN  registered selected product half.
REQ-015 Port ack_o  output  1  completion; ack_o = ack register AND stb_i.
REQ-016 Port busy_o  output  1  high in any state other than IDLE.

Function
REQ-017 States: IDLE, MUL, NEGATE, DONE; 2-bit encoded.
REQ-018 IDLE: if ack register set, it takes the value of stb_i (clears once stb_i drops); new request accepted only when stb_i & cyc_i & ~ack register.
REQ-019 Accept: latch |op_1| and |op_2| (negate only if signed flag set and MSB set), latch sign = (op_1 neg) XOR (op_2 neg), clear 2*XLEN accumulator, iteration count = 0, go MUL.
REQ-020 MUL: each cycle add sum over k of (|op_1| << k) for each set bit k of the low BITS_PER_CYCLE bits of the multiplier register; then multiplicand register shifts left and multiplier register shifts right by BITS_PER_CYCLE.
REQ-021 MUL exits after XLEN/BITS_PER_CYCLE cycles, or earlier when EARLY_TERMINATE=1 and the post-shift multiplier register is zero; exit to NEGATE if sign latch set, else DONE.
REQ-022 EARLY_TERMINATE=1 with |op_2| = 0 at accept: exactly one MUL cycle, result 0, sign ignored (no NEGATE).
REQ-023 NEGATE: accumulator = two's complement of accumulator over 2*XLEN bits; go DONE.
REQ-024 DONE: result_o <= selected half per result_upper_i; ack register <= 1; full product and operand/signedness tags stored when RESULT_CACHE=1; go IDLE.
REQ-025 Full-length latency (no early exit, no cache): ack_o high XLEN/BITS_PER_CYCLE + 2 edges after accept edge, +1 when NEGATE taken.
REQ-026 Cache hit (RESULT_CACHE=1, cache valid, op_1_i, op_2_i and both signed flags equal to stored tags): accept goes directly to DONE using stored product; ack_o high 2 edges after accept edge regardless of result_upper_i.
REQ-027 Cache valid cleared by reset only; never hit when RESULT_CACHE=0.
REQ-028 stb_i dropped mid-operation: computation continues; ack register set in DONE, ack_o stays low, ack register cleared in IDLE next cycle while stb_i low.
REQ-029 Arithmetic exact for all operand pairs including most-negative value (e.g. 0x80000000 signed magnitude 0x80000000 unsigned).

Reset
REQ-030 Asserting rst_i at any time, including mid-MUL, immediately forces state IDLE, ack register 0, ack_o 0, busy_o 0, result_o 0, cache valid 0.
REQ-031 After rst_i deasserts, first request accepted on first rising edge where REQ-018 condition holds.

Verification
REQ-032 XLEN=32, BPC=2, EARLY_TERMINATE=0: 7 x 6 unsigned, lower -> result_o 0x0000002A, ack_o 18 edges after accept.
REQ-033 MULH: 0xFFFFFFFF x 0xFFFFFFFF both signed, upper -> 0x00000000; MULHU same operands -> 0xFFFFFFFE.
REQ-034 MULHSU: op_1 0xFFFFFFFF signed, op_2 0xFFFFFFFF unsigned, upper -> 0xFFFFFFFF, NEGATE observed.
REQ-035 Cache: MULH 0x12345678 x 0x9ABCDEF0 signed, then MUL same operands -> second ack after 2 edges, lower 0x242D2080.
REQ-036 Early terminate, BPC=1: op_2 = 1 -> ack 3 edges after accept; rst_i pulsed during MUL -> ack_o never asserts, busy_o 0 immediately.
REQ-037 XLEN=64, BPC=4: 0x8000000000000000 signed x 2 signed, upper -> 0xFFFFFFFFFFFFFFFF, lower 0.
